pulse_counter_mc: RTL

//  Multi-channel filtered pulse counter; successor to the single-channel level-filtered counter.

---
 rtl/pulse_counter_mc_pkg.sv | 26 ++
 rtl/pulse_counter_mc_filter.sv | 39 +++
 rtl/pulse_counter_mc.sv | 99 +++++++++
 3 files changed

// File: rtl/pulse_counter_mc_pkg.sv
// Shared definitions for the multi-channel filtered pulse counter.
// Holds the per-channel counting mode encoding and parameter range limits.
package pulse_counter_mc_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam int unsigned CH_NUM_MIN    = 1;
    localparam int unsigned CH_NUM_MAX    = 16;
    localparam int unsigned CNT_WIDTH_MIN = 2;
    localparam int unsigned CNT_WIDTH_MAX = 32;
    localparam int unsigned FILT_LEN_MIN  = 1;
    localparam int unsigned FILT_LEN_MAX  = 255;

    // True when a parameter set lies inside the supported ranges.
    function automatic bit params_ok(input int unsigned ch_num,
                                     input int unsigned cnt_width,
                                     input int unsigned filt_len);
        return (ch_num >= CH_NUM_MIN) && (ch_num <= CH_NUM_MAX) &&
               (cnt_width >= CNT_WIDTH_MIN) && (cnt_width <= CNT_WIDTH_MAX) &&
               (filt_len >= FILT_LEN_MIN) && (filt_len <= FILT_LEN_MAX);
    endfunction

endpackage

// File: rtl/pulse_counter_mc_filter.sv
// One channel front end: 2-FF synchroniser, high-level duration filter, one-shot event.
// o_evt pulses once per high level that lasts at least FILT_LEN synchronised cycles.
module pulse_filter #(
    parameter int unsigned FILT_LEN = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_evt
);

    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN);
    localparam logic [FW-1:0] FILT_PRE = FW'(FILT_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [FW-1:0] filt;

    // Filter saturates at FILT_MAX, so the FILT_PRE match fires only once per level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= '0;
            o_evt <= 1'b0;
        end else begin
            sync1 <= i_in;
            sync2 <= sync1;
            if (!sync2) begin
                filt <= '0;
            end else if (filt != FILT_MAX) begin
                filt <= filt + FW'(1);
            end
            o_evt <= sync2 && (filt == FILT_PRE);
        end
    end

endmodule

// File: rtl/pulse_counter_mc.sv
// Multi-channel filtered pulse counter with per-channel wrap/saturate mode,
// sticky overflow flags and a global snapshot register bank.
module pulse_counter_mc
    import pulse_counter_mc_pkg::*;
#(
    parameter int unsigned       CH_NUM    = 4,
    parameter int unsigned       CNT_WIDTH = 8,
    parameter int unsigned       FILT_LEN  = 16,
    parameter logic [CH_NUM-1:0] SAT_MODE  = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [CH_NUM-1:0]           i_cnt_in,
    input  logic [CH_NUM-1:0]           i_cnt_en,
    input  logic [CH_NUM-1:0]           i_cnt_clr,
    input  logic                        i_snap,
    output logic [CH_NUM*CNT_WIDTH-1:0] o_cnt,
    output logic [CH_NUM*CNT_WIDTH-1:0] o_snap,
    output logic                        o_snap_vld,
    output logic [CH_NUM-1:0]           o_ovf
);

    localparam int unsigned CW = CNT_WIDTH + 1;

    if (!params_ok(CH_NUM, CNT_WIDTH, FILT_LEN)) begin : g_param_err
        $error("pulse_counter_mc: CH_NUM, CNT_WIDTH or FILT_LEN out of range");
    end

    logic [CH_NUM-1:0]                evt;
    logic [CH_NUM-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [CH_NUM-1:0][CNT_WIDTH-1:0] cnt_inc;
    logic [CH_NUM-1:0][CNT_WIDTH-1:0] snap_q;
    logic [CH_NUM-1:0]                carry;
    logic [CH_NUM-1:0]                ovf_q;
    logic                             snap_vld_q;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        pulse_filter #(
            .FILT_LEN (FILT_LEN)
        ) u_filter (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_in  (i_cnt_in[n]),
            .o_evt (evt[n])
        );
    end

    // Incremented value per channel; the carry-out flags the all-ones rollover.
    always_comb begin
        cnt_inc = '0;
        carry   = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            {carry[n], cnt_inc[n]} = {1'b0, cnt_q[n]} + CW'(1);
        end
    end

    // Per-channel counters; clear beats a same-cycle event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int n = 0; n < CH_NUM; n++) begin
                if (i_cnt_clr[n]) begin
                    cnt_q[n] <= '0;
                    ovf_q[n] <= 1'b0;
                end else if (evt[n] && i_cnt_en[n]) begin
                    if (carry[n]) begin
                        ovf_q[n] <= 1'b1;
                    end
                    if (carry[n] && (cnt_mode_e'(SAT_MODE[n]) == MODE_SAT)) begin
                        cnt_q[n] <= cnt_q[n];
                    end else begin
                        cnt_q[n] <= cnt_inc[n];
                    end
                end
            end
        end
    end

    // Snapshot captures pre-update counter values for all channels at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            if (i_snap) begin
                snap_q <= cnt_q;
            end
            snap_vld_q <= i_snap;
        end
    end

    assign o_cnt      = cnt_q;
    assign o_snap     = snap_q;
    assign o_snap_vld = snap_vld_q;
    assign o_ovf      = ovf_q;

endmodule
